// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding, the 4x4
// keypad legend table and constant-width helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    // Raw code (col*4 + row) to legend code for a standard 4x4 keypad.
    localparam logic [3:0] KEY_MAP [0:15] = '{
        4'd1,  4'd4,  4'd7,  4'd14,
        4'd2,  4'd5,  4'd8,  4'd0,
        4'd3,  4'd6,  4'd9,  4'd15,
        4'd10, 4'd11, 4'd12, 4'd13
    };

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Index width over 'count' items; a single item still needs one bit.
    function automatic int idx_width(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

endpackage

// File: rtl/keypad_code_map.sv
// Raw scan code to keypad legend lookup; a plain pass-through when mapping is
// disabled or the matrix is not 4x4.
module keypad_code_map
    import keypad_pkg::*;
#(
    parameter int MAP_EN = 1,
    parameter int CODE_W = 4
) (
    input  logic [CODE_W-1:0] raw_code,
    output logic [CODE_W-1:0] code
);

    generate
        if (MAP_EN != 0 && CODE_W == 4) begin : g_map
            logic [3:0] idx;
            assign idx  = raw_code[3:0];
            assign code = CODE_W'(KEY_MAP[idx]);
        end else begin : g_raw
            assign code = raw_code;
        end
    endgenerate

endmodule

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: column drive, row synchronisation, single-key
// debounce FSM, optional legend mapping and a small event FIFO.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int  ROWS       = 4,
    parameter int  COLS       = 4,
    parameter int  SCAN_DIV   = 1000,
    parameter int  DB_SAMPLES = 4,
    parameter int  FIFO_DEPTH = 4,
    parameter int  MAP_EN     = 1,
    localparam int CODE_W     = idx_width(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   rows_n,
    output logic [COLS-1:0]   col_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_down,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int ROW_W = idx_width(ROWS);
    localparam int COL_W = idx_width(COLS);
    localparam int DIV_W = idx_width(SCAN_DIV);
    localparam int PTR_W = idx_width(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MAP_ACTIVE = (MAP_EN != 0 && ROWS == 4 && COLS == 4) ? 1 : 0;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [3:0]       DB_TARGET = 4'(DB_SAMPLES);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    logic [ROWS-1:0]   sync_1;
    logic [ROWS-1:0]   rows_sync;
    logic [DIV_W-1:0]  div_cnt;
    logic              sample_tick;

    scan_state_t       state;
    scan_state_t       state_d;
    logic [COL_W-1:0]  col_idx;
    logic [COL_W-1:0]  col_d;
    logic [COL_W-1:0]  col_next;
    logic [ROW_W-1:0]  row_lat;
    logic [ROW_W-1:0]  row_d;
    logic [ROW_W-1:0]  low_idx;
    logic [3:0]        db_cnt;
    logic [3:0]        cnt_d;
    logic [3:0]        cnt_inc;
    logic              any_low;
    logic              row_low;
    logic              push;

    logic [CODE_W-1:0] raw_code;
    logic [CODE_W-1:0] mapped_code;

    logic [CODE_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full;
    logic              do_push;
    logic              do_pop;
    logic              drop;

    // Rows idle high, so the synchroniser resets to "no key".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1    <= '1;
            rows_sync <= '1;
        end else begin
            sync_1    <= rows_n;
            rows_sync <= sync_1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (sample_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign sample_tick = (div_cnt == DIV_LAST);

    // Lowest row index wins when several rows read low together.
    always_comb begin
        low_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rows_sync[i]) begin
                low_idx = ROW_W'(i);
            end
        end
    end

    assign any_low  = ~&rows_sync;
    assign row_low  = ~rows_sync[row_lat];
    assign col_next = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
    assign cnt_inc  = db_cnt + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SCAN;
            col_idx <= '0;
            row_lat <= '0;
            db_cnt  <= '0;
        end else begin
            state   <= state_d;
            col_idx <= col_d;
            row_lat <= row_d;
            db_cnt  <= cnt_d;
        end
    end

    // Decisions are only taken on the sample tick at the end of a dwell.
    always_comb begin
        state_d = state;
        col_d   = col_idx;
        row_d   = row_lat;
        cnt_d   = db_cnt;
        push    = 1'b0;
        if (sample_tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        state_d = DEBOUNCE;
                        row_d   = low_idx;
                        cnt_d   = 4'd0;
                    end else begin
                        col_d = col_next;
                    end
                end
                DEBOUNCE: begin
                    if (!row_low) begin
                        state_d = SCAN;
                        cnt_d   = 4'd0;
                        col_d   = col_next;
                    end else if (cnt_inc == DB_TARGET) begin
                        state_d = PRESSED;
                        cnt_d   = 4'd0;
                        push    = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!row_low) begin
                        if (DB_TARGET == 4'd1) begin
                            state_d = SCAN;
                            cnt_d   = 4'd0;
                            col_d   = col_next;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (row_low) begin
                        state_d = PRESSED;
                        cnt_d   = 4'd0;
                    end else if (cnt_inc == DB_TARGET) begin
                        state_d = SCAN;
                        cnt_d   = 4'd0;
                        col_d   = col_next;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    assign col_n    = ~(COLS'(1) << col_idx);
    assign key_down = (state == PRESSED) || (state == RELEASE);
    assign raw_code = CODE_W'(col_idx) * CODE_W'(ROWS) + CODE_W'(row_lat);

    keypad_code_map #(
        .MAP_EN (MAP_ACTIVE),
        .CODE_W (CODE_W)
    ) u_code_map (
        .raw_code (raw_code),
        .code     (mapped_code)
    );

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign key_valid = (fifo_cnt != '0);
    assign fifo_full = (fifo_cnt == FIFO_FULL);
    assign do_pop    = key_ready && key_valid;
    assign do_push   = push && (!fifo_full || do_pop);
    assign drop      = push && fifo_full && !do_pop;
    assign key_code  = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= mapped_code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a mapped and a raw-code scanner share one simulated
// 4x4 keypad; results are compared against tables and a queue model.
`timescale 1ns/1ps
module tb_keypad_scan;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int SCAN_DIV   = 4;
    localparam int DB_SAMPLES = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_ready;
    logic        ovf_clr;
    logic [15:0] keys;

    logic [3:0] rows_n_m, col_n_m, key_code_m;
    logic       key_valid_m, key_down_m, overflow_m;
    logic [3:0] rows_n_r, col_n_r, key_code_r;
    logic       key_valid_r, key_down_r, overflow_r;

    int tests_run    = 0;
    int tests_failed = 0;
    int kd_falls     = 0;
    logic kd_prev    = 1'b0;

    int legend [16] = '{1, 4, 7, 14, 2, 5, 8, 0, 3, 6, 9, 15, 10, 11, 12, 13};

    typedef struct {
        logic [15:0] mask;
        int          exp_m;
        int          exp_r;
    } hold_t;

    always #5 clk = ~clk;

    // Key bit c*4+r shorts column c to row r.
    function automatic logic [3:0] rowsFor(input logic [3:0] coln, input logic [15:0] pressed);
        logic [3:0] r;
        r = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (!coln[c] && pressed[c * 4 + k]) r[k] = 1'b0;
            end
        end
        return r;
    endfunction

    assign rows_n_m = rowsFor(col_n_m, keys);
    assign rows_n_r = rowsFor(col_n_r, keys);

    keypad_scan #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DB_SAMPLES(DB_SAMPLES),
        .FIFO_DEPTH(FIFO_DEPTH), .MAP_EN(1)
    ) dut_map (
        .clk(clk), .reset(reset), .rows_n(rows_n_m), .col_n(col_n_m),
        .key_code(key_code_m), .key_valid(key_valid_m), .key_ready(key_ready),
        .key_down(key_down_m), .overflow(overflow_m), .ovf_clr(ovf_clr)
    );

    keypad_scan #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DB_SAMPLES(DB_SAMPLES),
        .FIFO_DEPTH(FIFO_DEPTH), .MAP_EN(0)
    ) dut_raw (
        .clk(clk), .reset(reset), .rows_n(rows_n_r), .col_n(col_n_r),
        .key_code(key_code_r), .key_valid(key_valid_r), .key_ready(key_ready),
        .key_down(key_down_r), .overflow(overflow_r), .ovf_clr(ovf_clr)
    );

    always @(negedge clk) begin
        if (kd_prev && !key_down_m) kd_falls++;
        kd_prev = key_down_m;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] mask, input int cycles);
        keys = mask;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic waitKeyDown(input logic level, input string name, input int limit);
        int n;
        n = 0;
        while (key_down_m !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, int'(key_down_m), int'(level));
    endtask

    // Lands on the first negedge of a fresh dwell of the target column.
    task automatic waitForCol(input logic [3:0] target, input string name);
        int n;
        n = 0;
        while (col_n_m === target && n < 40) begin
            @(negedge clk);
            n++;
        end
        while (col_n_m !== target && n < 80) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, int'(col_n_m), int'(target));
    endtask

    task automatic popCheck(input string name, input int exp_m, input int exp_r);
        checkOutput({name, " valid"}, int'(key_valid_m), 1);
        checkOutput({name, " code"}, int'(key_code_m), exp_m);
        checkOutput({name, " raw code"}, int'(key_code_r), exp_r);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic pressRelease(input logic [15:0] mask, input string name);
        applyStimulus(mask, 1);
        waitKeyDown(1'b1, {name, " press"}, 200);
        applyStimulus(16'h0000, 1);
        waitKeyDown(1'b0, {name, " release"}, 200);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        hold_t       holds [5];
        logic [15:0] ovf_keys [5];
        int          ovf_raw [4];
        int          exp_q_m [$];
        int          exp_q_r [$];
        bit          model_ovf;
        int          falls_before;
        logic [15:0] m;
        int          key;
        int          npop;

        holds[0] = '{16'h0001, 1, 0};
        holds[1] = '{16'h0008, 14, 3};
        holds[2] = '{16'h0080, 0, 7};
        holds[3] = '{16'h8000, 13, 15};
        holds[4] = '{16'h00A0, 5, 5};
        ovf_keys = '{16'h0001, 16'h0010, 16'h0100, 16'h0002, 16'h0020};
        ovf_raw  = '{0, 4, 8, 1};

        reset     = 1'b1;
        key_ready = 1'b0;
        ovf_clr   = 1'b0;
        keys      = 16'h0000;
        repeat (3) @(negedge clk);
        checkOutput("reset col_n", int'(col_n_m), 14);
        checkOutput("reset raw col_n", int'(col_n_r), 14);
        checkOutput("reset key_valid", int'(key_valid_m), 0);
        checkOutput("reset key_down", int'(key_down_m), 0);
        checkOutput("reset overflow", int'(overflow_m), 0);
        reset = 1'b0;

        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            checkOutput($sformatf("idle col_n cycle %0d", k), int'(col_n_m), 15 - (1 << ((k / 4) % 4)));
        end
        checkOutput("idle key_valid", int'(key_valid_m), 0);
        checkOutput("idle raw key_valid", int'(key_valid_r), 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(holds[i].mask, 1);
            waitKeyDown(1'b1, $sformatf("hold %0d key_down rise", i), 200);
            popCheck($sformatf("hold %0d", i), holds[i].exp_m, holds[i].exp_r);
            checkOutput($sformatf("hold %0d empty after pop", i), int'(key_valid_m), 0);
            applyStimulus(16'h0000, 1);
            waitKeyDown(1'b0, $sformatf("hold %0d key_down fall", i), 200);
            applyStimulus(16'h0000, 8);
            checkOutput($sformatf("hold %0d no repeat", i), int'(key_valid_m), 0);
        end

        // One low sample on (col2,row2): column is held for one dwell, then moves on.
        waitForCol(4'b1011, "glitch reach col2");
        applyStimulus(16'h0400, SCAN_DIV);
        checkOutput("glitch col held", int'(col_n_m), 11);
        checkOutput("glitch key_down", int'(key_down_m), 0);
        applyStimulus(16'h0000, SCAN_DIV);
        checkOutput("glitch col advanced", int'(col_n_m), 7);
        applyStimulus(16'h0000, 40);
        checkOutput("glitch no event", int'(key_valid_m), 0);
        checkOutput("glitch no key_down", int'(key_down_m), 0);

        falls_before = kd_falls;
        applyStimulus(16'h0200, 1);
        waitKeyDown(1'b1, "long hold rise", 200);
        applyStimulus(16'h0200, 50 * SCAN_DIV);
        checkOutput("long hold still down", int'(key_down_m), 1);
        applyStimulus(16'h0000, 2 * SCAN_DIV);
        applyStimulus(16'h0200, 0);
        waitKeyDown(1'b0, "long hold fall", 20);
        waitKeyDown(1'b1, "long hold second rise", 200);
        checkOutput("long hold single fall", kd_falls - falls_before, 1);
        popCheck("long hold event 1", 6, 9);
        popCheck("long hold event 2", 6, 9);
        checkOutput("long hold exactly two", int'(key_valid_m), 0);
        applyStimulus(16'h0000, 1);
        waitKeyDown(1'b0, "long hold final fall", 200);

        for (int i = 0; i < 5; i++) begin
            pressRelease(ovf_keys[i], $sformatf("ovf key %0d", i));
            if (i == 3) checkOutput("ovf not yet set", int'(overflow_m), 0);
        end
        checkOutput("ovf set", int'(overflow_m), 1);
        checkOutput("ovf raw set", int'(overflow_r), 1);
        for (int i = 0; i < 4; i++) begin
            popCheck($sformatf("ovf pop %0d", i), i + 1, ovf_raw[i]);
        end
        checkOutput("ovf drained", int'(key_valid_m), 0);
        checkOutput("ovf sticky", int'(overflow_m), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checkOutput("ovf cleared", int'(overflow_m), 0);
        checkOutput("ovf raw cleared", int'(overflow_r), 0);

        // Reset lands mid-debounce of (col2,row1); column drive must snap back at once.
        waitForCol(4'b1011, "rst reach col2");
        applyStimulus(16'h0200, SCAN_DIV + 1);
        checkOutput("rst debounce col held", int'(col_n_m), 11);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst async col_n", int'(col_n_m), 14);
        checkOutput("rst raw async col_n", int'(col_n_r), 14);
        checkOutput("rst key_down", int'(key_down_m), 0);
        keys = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(16'h0000, 40);
        checkOutput("rst no event", int'(key_valid_m), 0);

        model_ovf = 1'b0;
        for (int it = 0; it < 40; it++) begin
            key = int'($urandom_range(15));
            m = 16'h0000;
            m[key] = 1'b1;
            applyStimulus(m, 1);
            waitKeyDown(1'b1, $sformatf("rand %0d press", it), 200);
            if (exp_q_m.size() < FIFO_DEPTH) begin
                exp_q_m.push_back(legend[key]);
                exp_q_r.push_back(key);
            end else begin
                model_ovf = 1'b1;
            end
            checkOutput($sformatf("rand %0d overflow", it), int'(overflow_m), int'(model_ovf));
            checkOutput($sformatf("rand %0d valid", it), int'(key_valid_m), int'(exp_q_m.size() > 0));
            applyStimulus(m, int'($urandom_range(12)));
            applyStimulus(16'h0000, 1);
            waitKeyDown(1'b0, $sformatf("rand %0d release", it), 200);
            npop = int'($urandom_range(2));
            for (int p = 0; p < npop; p++) begin
                if (exp_q_m.size() > 0) begin
                    popCheck($sformatf("rand %0d pop", it), exp_q_m.pop_front(), exp_q_r.pop_front());
                end else begin
                    key_ready = 1'b1;
                    @(negedge clk);
                    key_ready = 1'b0;
                    checkOutput($sformatf("rand %0d empty pop", it), int'(key_valid_m), 0);
                end
            end
            if ($urandom_range(5) == 0) begin
                ovf_clr = 1'b1;
                @(negedge clk);
                ovf_clr = 1'b0;
                model_ovf = 1'b0;
                checkOutput($sformatf("rand %0d ovf_clr", it), int'(overflow_m), 0);
            end
            applyStimulus(16'h0000, int'($urandom_range(6)));
        end
        while (exp_q_m.size() > 0) begin
            popCheck("rand drain", exp_q_m.pop_front(), exp_q_r.pop_front());
        end
        checkOutput("rand final empty", int'(key_valid_m), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Parametrised matrix-keypad front end that replaces the fixed 4×4 scan-code converter with a complete scanner. It drives the keypad columns, synchronises and debounces the row returns, and converts the pressed key to a mapped code through the standard 4×4 keypad table or passes the raw code through. Codes are queued in a small FIFO toward the display/control logic over a valid/ready handshake.

## Interface
- ROWS, 4: keypad rows, 1..8.
- COLS, 4: keypad columns, 1..8.
- SCAN_DIV, 1000: clocks each column is driven. Must be ≥4.
- DB_SAMPLES, 4: consecutive matching samples needed to accept a press or a release. Range 1..15.
- FIFO_DEPTH, 4: event queue depth. Power of 2, ≥2.
- MAP_EN, 1: 1 applies the keypad table (legal only with ROWS=COLS=4); 0 outputs the raw code.
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- rows_n, input, ROWS: row returns, active-low, asynchronous to clk.
- col_n, output, COLS: column drive, active-low, exactly one bit low at all times.
- key_code, output, CODE_W = clog2(ROWS*COLS): head-of-FIFO code. Meaningful only while key_valid=1.
- key_valid, output, 1: FIFO not empty.
- key_ready, input, 1: consumer pop strobe.
- key_down, output, 1: a debounced key is currently held.
- overflow, output, 1: sticky flag set when a press is dropped because the FIFO is full.
- ovf_clr, input, 1: clears overflow.

## Operation
- rows_n passes through a 2-flop synchroniser. One sample is taken on the last clock of each column dwell.
- Raw code is col_index*ROWS + row_index. With MAP_EN=1, raw codes 0..15 map to 1,4,7,14,2,5,8,0,3,6,9,15,10,11,12,13.
- If several rows read low, the lowest row index wins. Only one key is tracked; other keys are ignored while in DEBOUNCE or PRESSED.
- The FSM has states SCAN, DEBOUNCE, PRESSED and RELEASE.
  - SCAN: advances the column every SCAN_DIV clocks and wraps from COLS-1 to 0. A sample with any row low latches (col,row) and moves to DEBOUNCE, holding the current column.
  - DEBOUNCE: each sample where the latched row is low increments the count. A mismatching sample returns to SCAN and advances the column. When the count reaches DB_SAMPLES, the FSM pushes the code, moves to PRESSED and sets key_down=1.
  - PRESSED: still holding the column. A sample with the latched row high moves to RELEASE with count=1.
  - RELEASE: each sample with the row high increments the count. A sample with the row low returns to PRESSED. When the count reaches DB_SAMPLES, key_down=0, the FSM returns to SCAN and the column advances.
- FIFO push while full drops the push and sets overflow. Push and pop in the same cycle while full are both accepted and nothing is dropped. A pop while empty is ignored.
- If ovf_clr and an overflow event occur in the same cycle, the set wins.

## Timing
- Reset values: col_n = all ones except bit 0 low. FSM in SCAN. Counters 0. FIFO empty. key_valid=0, key_down=0, overflow=0.
- Press to push: the push occurs on the clock edge of the DB_SAMPLES-th matching sample. key_valid and key_down rise on the following cycle.
- Minimum latency from a clean press (already synchronised) to key_valid is DB_SAMPLES*SCAN_DIV + 1 clocks, measured from the first matching sample.
- Pop: key_ready=1 with key_valid=1 removes the head. The new head, or key_valid=0, appears on the next cycle.
- Synchroniser delay is 2 clocks, always inside a column dwell because SCAN_DIV ≥ 4.
- A reset mid-debounce or mid-press aborts with no event pushed and col_n returns to its reset value immediately (asynchronous).

## Structure
- keypad_pkg holds:
  - FSM state encoding: SCAN=0, DEBOUNCE=1, PRESSED=2, RELEASE=3.
  - the 16-entry 4×4 map constant.
  - a clog2 function.
- Sub-module keypad_code_map: combinational raw-to-mapped lookup using the package table, gated by MAP_EN.
- The FIFO stays inline in keypad_scan.

## Test plan
The bench uses SCAN_DIV=4, DB_SAMPLES=2, FIFO_DEPTH=4 and ROWS=COLS=4.
- Reset, then idle → col_n cycles 1110, 1101, 1011, 0111, changing every 4 clocks; key_valid stays 0.
- Clean holds on (col0,row0), (col0,row3), (col1,row3) and (col3,row3), each released between presses → one event per hold with key_code 1, 14, 0 and 13. With MAP_EN=0 the same holds yield raw codes 0, 3, 7 and 15.
- Row 2 on column 2 low for a single sample only → no event; scanning resumes and col_n advances.
- Key held for 50 samples, released for 2 samples, then pressed again → exactly two events; key_down falls once between them.
- key_ready=0 during 5 distinct presses (codes 1,2,3,4,5) → FIFO holds 1,2,3,4, the 5th is dropped and overflow=1. Popping yields 1,2,3,4 in order; ovf_clr then clears overflow.
- reset pulsed during DEBOUNCE on (col2,row1) → no event, key_down=0, col_n=1110 immediately.
